// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller with cycle and retire counters
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_busy,
    input  logic        dmem_busy,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    input  logic        ifid_use_rs1,
    input  logic        ifid_use_rs2,
    input  logic        branch_taken,
    input  logic        wb_valid,
    output logic        cpu_stall,
    output logic        pc_write,
    output logic        ifid_hold,
    output logic        if_flush,
    output logic        id_flush,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instr_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        flush_pend_q, flush_pend_d;
    logic [63:0] cycle_cnt_q, cycle_cnt_d;
    logic [63:0] instr_cnt_q, instr_cnt_d;
    logic        load_use;

    assign cpu_stall = imem_busy | dmem_busy;

    assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                      ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                       (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            flush_pend_q <= 1'b0;
            cycle_cnt_q  <= 64'd0;
            instr_cnt_q  <= 64'd0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            cycle_cnt_q  <= cycle_cnt_d;
            instr_cnt_q  <= instr_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        pc_write     = 1'b1;
        ifid_hold    = 1'b0;
        if_flush     = 1'b0;
        id_flush     = 1'b0;

        case (state_q)
            ST_RUN:      state_d = cpu_stall ? ST_MEM_WAIT : ST_RUN;
            ST_MEM_WAIT: state_d = cpu_stall ? ST_MEM_WAIT :
                                   (flush_pend_q ? ST_FLUSH : ST_RUN);
            ST_FLUSH:    state_d = cpu_stall ? ST_MEM_WAIT : ST_RUN;
            default:     state_d = ST_RUN;
        endcase

        // A redirect seen during a stall must be replayed once the stall lifts;
        // a new one arriving while leaving FLUSH wins over the clear.
        if (branch_taken && cpu_stall)
            flush_pend_d = 1'b1;
        else if (state_q == ST_FLUSH)
            flush_pend_d = 1'b0;

        if (cpu_stall) begin
            pc_write  = 1'b0;
            ifid_hold = 1'b1;
        end else if (branch_taken || (state_q == ST_FLUSH)) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
        end else if (load_use) begin
            pc_write  = 1'b0;
            ifid_hold = 1'b1;
            id_flush  = 1'b1;
        end

        cycle_cnt_d = cycle_cnt_q + 64'd1;
        instr_cnt_d = (wb_valid && !cpu_stall) ? instr_cnt_q + 64'd1 : instr_cnt_q;
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
    assign state     = state_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: imem_busy  in  1  instruction-fetch AXI transaction outstanding.
REQ-004 SHALL have ports: dmem_busy  in  1  data AXI transaction outstanding.
REQ-005 SHALL have ports: idex_mem_read  in  1  instruction in EX is a load.
REQ-006 SHALL have ports: idex_rd  in  5  destination register of the instruction in EX.
REQ-007 SHALL have ports: ifid_rs1, ifid_rs2  in  5 each  source registers of the instruction in ID.
REQ-008 SHALL have ports: ifid_use_rs1, ifid_use_rs2  in  1 each  ID instruction reads rs1/rs2.
REQ-009 SHALL have ports: branch_taken  in  1  EX resolved taken branch or jump (redirect).
REQ-010 SHALL have ports: wb_valid  in  1  valid instruction in WB this cycle.
REQ-011 SHALL have ports: cpu_stall  out  1  freeze all pipeline registers.
REQ-012 SHALL have ports: pc_write  out  1  1 = PC may update.
REQ-013 SHALL have ports: ifid_hold  out  1  1 = IF/ID register holds its value.
REQ-014 SHALL have ports: if_flush  out  1  zero the IF/ID register.
REQ-015 SHALL have ports: id_flush  out  1  insert a bubble into ID/EX.
REQ-016 SHALL have ports: cycle_cnt  out  64  cycles since reset.
REQ-017 SHALL have ports: instr_cnt  out  64  retired instructions.
REQ-018 SHALL have ports: state  out  2  FSM state (RUN=0, MEM_WAIT=1, FLUSH=2).

Function
REQ-019 SHALL drive cpu_stall = imem_busy | dmem_busy combinationally in every state.
REQ-020 SHALL transition RUN->MEM_WAIT on a clock edge where cpu_stall=1.
REQ-021 SHALL stay in MEM_WAIT while cpu_stall=1.
REQ-022 SHALL exit MEM_WAIT when cpu_stall=0: go to FLUSH if flush_pend=1, else to RUN.
REQ-023 SHALL stay in FLUSH for exactly one cycle, then go to RUN (or to MEM_WAIT if cpu_stall=1).
REQ-024 SHALL hold internal flag flush_pend: set on any edge where branch_taken=1 and cpu_stall=1; cleared on the edge leaving FLUSH.
REQ-025 SHALL detect a load-use hazard: idex_mem_read=1 & idex_rd!=0 & ((ifid_use_rs1 & ifid_rs1==idex_rd) | (ifid_use_rs2 & ifid_rs2==idex_rd)).
REQ-026 SHALL drive pc_write=1, ifid_hold=0, if_flush=0, id_flush=0 in RUN when cpu_stall=0, no hazard and no branch.
REQ-027 SHALL handle branch_taken=1 with cpu_stall=0 (RUN or FLUSH): if_flush=1, id_flush=1, pc_write=1, ifid_hold=0, same cycle.
REQ-028 SHALL handle a load-use hazard with cpu_stall=0, no branch and not FLUSH: pc_write=0, ifid_hold=1, id_flush=1, if_flush=0 for each cycle the condition holds.
REQ-029 SHALL give branch_taken priority over a load-use hazard in the same cycle.
REQ-030 SHALL, in FLUSH with cpu_stall=0: if_flush=1, id_flush=1, pc_write=1, ifid_hold=0.
REQ-031 SHALL, whenever cpu_stall=1: pc_write=0, ifid_hold=1, if_flush=0, id_flush=0, regardless of state, branch or hazard.
REQ-032 SHALL increment cycle_cnt by 1 every clock edge after reset; wraps 2^64-1 -> 0.
REQ-033 SHALL increment instr_cnt by 1 on edges where wb_valid=1 and cpu_stall=0; wraps 2^64-1 -> 0.
REQ-034 SHALL count a wb_valid held across a stall exactly once (on the release edge).

Reset
REQ-035 SHALL, while rst=1 (immediately, no clock needed), force state=RUN, flush_pend=0, cycle_cnt=0, instr_cnt=0.
REQ-036 SHALL abandon any MEM_WAIT/FLUSH and pending flush on reset mid-operation; combinational outputs then follow REQ-026..031 from RUN.

Verification
REQ-037 SHALL be verified by scenario "load-use": idex_mem_read=1, idex_rd=5, ifid_rs2=5, ifid_use_rs2=1, no busy -> pc_write=0, ifid_hold=1, id_flush=1 for that cycle; with rd=0 -> no stall.
REQ-038 SHALL be verified by scenario "branch vs hazard": branch_taken=1 with load-use true -> if_flush=1, id_flush=1, pc_write=1, ifid_hold=0.
REQ-039 SHALL be verified by scenario "branch during stall": dmem_busy=1 for 4 cycles with branch_taken=1 on cycle 2 -> no flush while busy; state 1 for 4 cycles, then 2 for one cycle with if_flush=id_flush=1, then 0.
REQ-040 SHALL be verified by scenario "counter freeze": wb_valid=1 constant, imem_busy=1 for 3 of 10 cycles -> instr_cnt=7, cycle_cnt=10.
REQ-041 SHALL be verified by scenario "async reset": assert rst mid-MEM_WAIT between edges -> state=0, counters=0 before the next edge; no pending flush after release.
REQ-042 SHALL be verified by scenario "wrap": force instr_cnt=2^64-1, one retire -> instr_cnt=0.
